muldiv_seq_unit: RTL
====================

Name: muldiv_seq_unit

Overview:
- Multi-cycle multiply/divide execution unit for the MIPS datapath.
- Consumer of the 4-bit ALUop produced by the opcode/ALUop decoding path. Executes the ALUop codes reserved for MULT/MULTU/DIV/DIVU.
- Iterative radix-2 shift-add multiplier and restoring divider, with a valid/ready handshake on both sides.
- Writes HI/LO results for the mfhi/mflo path.

Parameters:
WIDTH, 32, operand width in bits; hi/lo are each WIDTH bits.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  request present
start_ready  output  1  unit can accept a request (high only in IDLE)
aluop  input  4  operation code, sampled on accept
a  input  WIDTH  multiplicand / dividend
b  input  WIDTH  multiplier / divisor
res_valid  output  1  result held on hi/lo
res_ready  input  1  consumer takes result
hi  output  WIDTH  product upper half / remainder
lo  output  WIDTH  product lower half / quotient
div_by_zero  output  1  flag for the current result: divide with b==0
illegal_op  output  1  flag for the current result: aluop not a muldiv code

Behaviour:
- Reset (async, rst_n=0):
  - state goes to IDLE.
  - hi=0, lo=0, res_valid=0, div_by_zero=0, illegal_op=0.
  - start_ready=1.
  - An in-flight operation is discarded; no result is produced.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE:
  - Accept occurs on edge E0 when start_valid && start_ready.
  - Latch the operands. For signed ops (MULT, DIV), store |a| and |b| and record the result signs.
  - Go to RUN and clear the iteration counter.
  - Exception: illegal aluop, or DIV/DIVU with b==0, goes directly to DONE at E0+1.
- RUN: one iteration per edge, WIDTH iterations (edges E1..E_WIDTH).
  - Multiply: 2*WIDTH-bit accumulator; add the shifted multiplicand when the current multiplier bit is 1.
  - Divide: restoring shift-subtract; one quotient bit per iteration.
  - Counter width is clog2(WIDTH)+1. Leave RUN when the counter reaches WIDTH-1.
- FIX (edge E_WIDTH+1):
  - Apply two's-complement negation. Product is negated if a and b signs differ. Quotient is negated if signs differ. Remainder takes the sign of the dividend.
  - Load hi/lo and go to DONE.
- Latency: res_valid=1 after edge E0+WIDTH+1, i.e. 33 cycles at WIDTH=32. Exception paths take 1 cycle.
- DONE:
  - res_valid=1. hi/lo and both flags held stable while res_ready=0.
  - On res_valid && res_ready: go to IDLE and set res_valid=0. hi/lo keep their last value until the next FIX or exception load.
- start_valid outside IDLE is ignored. There is no back-to-back accept in the DONE handshake cycle.
- Divide by zero:
  - lo = all ones, hi = a (unmodified), div_by_zero=1.
  - Applies to signed and unsigned divides.
- Illegal op: hi=lo=0, illegal_op=1.
- Signed overflow, DIV MIN/-1: lo=MIN, hi=0 (the natural algorithm result); no flag.
- Flags clear on the next accept.
- Multiplier and divider share one accumulator register and one WIDTH+1-bit adder/subtractor.

Optional Feature:
MULDIV_EARLY_TERM_EN
- Defined: in multiply RUN, if the remaining unshifted multiplier bits are all zero, skip directly to FIX. Latency is variable, 2..WIDTH+1 cycles; for example b=0 or b=1 completes at E2. Results are identical. Divide is unaffected.
- Undefined: fixed latency of WIDTH+1 cycles for all multiply and divide ops.

Decomposition:
- Shared package muldiv_pkg:
  - ALUOP_MULT=4'b1100, ALUOP_MULTU=4'b1101, ALUOP_DIV=4'b1110, ALUOP_DIVU=4'b1111.
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, FIX=2'd2, DONE=2'd3.
  - Predicates is_signed and is_div.
- The ALUop decoder emits codes from this package.
- One sub-module: muldiv_absneg, a combinational conditional two's-complement negate of WIDTH bits. It is instantiated for operand conditioning and for result fix-up.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, res_ready=1 -> hi=0xFFFFFFFE lo=0x00000001, res_valid exactly 33 cycles after accept, start_ready=0 throughout.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=10 b=0 -> res_valid 1 cycle after accept, div_by_zero=1, lo=0xFFFFFFFF, hi=0x0000000A. Next accept clears the flag.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0, no flags. aluop=4'b0010 -> illegal_op=1, hi=lo=0 after 1 cycle.
- Hold res_ready=0 for 10 cycles in DONE with start_valid=1 -> hi/lo stable, no new accept. Raise res_ready -> IDLE next edge, start_ready=1.
- Assert rst_n=0 at iteration 15 of a MULTU -> immediately hi=lo=0, res_valid=0, start_ready=1. A fresh MULTU 6*7 then gives lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: ALUop codes,
// FSM state encoding and opcode predicates.
package muldiv_pkg;

    localparam logic [3:0] ALUOP_MULT  = 4'b1100;
    localparam logic [3:0] ALUOP_MULTU = 4'b1101;
    localparam logic [3:0] ALUOP_DIV   = 4'b1110;
    localparam logic [3:0] ALUOP_DIVU  = 4'b1111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

    function automatic logic is_signed(input logic [3:0] op);
        return (op == ALUOP_MULT) || (op == ALUOP_DIV);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == ALUOP_DIV) || (op == ALUOP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_absneg.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to restore result signs.
module muldiv_absneg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);

    assign result = neg ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/muldiv_seq_unit.sv
// Iterative radix-2 multiply / restoring divide unit producing HI/LO.
// Optional build macro MULDIV_EARLY_TERM_EN: multiply leaves RUN as soon as
// the remaining multiplier bits are zero.
module muldiv_seq_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;    // {hi part, lo part}: product or {remainder, quotient}
    logic [WIDTH-1:0]   opnd_q;   // multiplicand or divisor magnitude
    logic               div_q, neg_q, rneg_q, exc_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               res_valid_q, dbz_q, ill_q;

    logic             a_neg, b_neg, op_ill, op_dbz;
    logic [WIDTH-1:0] a_abs, b_abs;

    assign a_neg  = is_signed(aluop) & a[WIDTH-1];
    assign b_neg  = is_signed(aluop) & b[WIDTH-1];
    assign op_ill = ~is_muldiv(aluop);
    assign op_dbz = is_div(aluop) & (b == '0);

    muldiv_absneg #(.WIDTH(WIDTH)) u_abs_a (.value(a), .neg(a_neg), .result(a_abs));
    muldiv_absneg #(.WIDTH(WIDTH)) u_abs_b (.value(b), .neg(b_neg), .result(b_abs));

    logic [WIDTH:0]     add_x, add_y, add_s;
    logic [2*WIDTH-1:0] acc_step;
    logic               last_iter;
`ifdef MULDIV_EARLY_TERM_EN
    logic [WIDTH-1:0]   mul_rest;
`endif

    // One iteration through the shared WIDTH+1-bit adder/subtractor
    always_comb begin
        add_y = {1'b0, opnd_q};
        if (div_q) begin
            add_x = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        end else begin
            add_x = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        end
        add_s = add_x + (div_q ? ~add_y : add_y) + {{WIDTH{1'b0}}, div_q};
        if (div_q) begin
            // Non-negative difference means the divisor fits: keep it, quotient bit 1
            if (!add_s[WIDTH]) begin
                acc_step = {add_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {add_x[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else if (acc_q[0]) begin
            acc_step = {add_s, acc_q[WIDTH-1:1]};
        end else begin
            acc_step = {add_x, acc_q[WIDTH-1:1]};
        end
        last_iter = (cnt_q == CW'(WIDTH - 1));
`ifdef MULDIV_EARLY_TERM_EN
        // Unconsumed multiplier bits live in acc_q[WIDTH-1-cnt_q:1]
        mul_rest = (acc_q[WIDTH-1:0] & ({WIDTH{1'b1}} >> cnt_q)) >> 1;
        if (!div_q && (mul_rest == '0)) begin
            last_iter = 1'b1;
        end
`endif
    end

    logic [2*WIDTH-1:0] prod;
    logic               lo_neg, hi_neg, hi_inv;
    logic [WIDTH-1:0]   lo_fix, hi_fix, hi_res;

    // Sign restoration; a 2W-bit product negates as {~hi, -lo} unless lo is zero
    always_comb begin
        prod = acc_q;
`ifdef MULDIV_EARLY_TERM_EN
        if (!div_q && !exc_q) begin
            prod = acc_q >> (CW'(WIDTH) - cnt_q);
        end
`endif
        lo_neg = ~exc_q & neg_q;
        hi_neg = ~exc_q & (div_q ? rneg_q : (neg_q & (prod[WIDTH-1:0] == '0)));
        hi_inv = ~exc_q & ~div_q & neg_q & (prod[WIDTH-1:0] != '0);
    end

    muldiv_absneg #(.WIDTH(WIDTH)) u_fix_lo (
        .value(prod[WIDTH-1:0]), .neg(lo_neg), .result(lo_fix)
    );
    muldiv_absneg #(.WIDTH(WIDTH)) u_fix_hi (
        .value(prod[2*WIDTH-1:WIDTH]), .neg(hi_neg), .result(hi_fix)
    );

    assign hi_res = hi_inv ? ~prod[2*WIDTH-1:WIDTH] : hi_fix;

    // Control FSM with registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            div_q       <= 1'b0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            exc_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            res_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_valid) begin
                        cnt_q  <= '0;
                        div_q  <= is_div(aluop);
                        neg_q  <= a_neg ^ b_neg;
                        rneg_q <= a_neg;
                        dbz_q  <= op_dbz & ~op_ill;
                        ill_q  <= op_ill;
                        exc_q  <= op_dbz | op_ill;
                        opnd_q <= is_div(aluop) ? b_abs : a_abs;
                        if (op_ill) begin
                            acc_q   <= '0;
                            state_q <= StFix;
                        end else if (op_dbz) begin
                            acc_q   <= {a, {WIDTH{1'b1}}};
                            state_q <= StFix;
                        end else begin
                            acc_q   <= {{WIDTH{1'b0}}, is_div(aluop) ? a_abs : b_abs};
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_iter) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    hi_q        <= hi_res;
                    lo_q        <= lo_fix;
                    res_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign start_ready = (state_q == StIdle);
    assign res_valid   = res_valid_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;
    assign illegal_op  = ill_q;

endmodule
